// File: rtl/mem_stage_if.sv
// mem_stage_if -- cache-side bus of the MEM pipeline stage.
//
//   cache_addr      word-aligned request address
//   cache_re        read strobe, high only while a read request is active
//   cache_we        write strobe, high only while a write request is active
//   cache_byte_en   byte enables, bit 3 selects lane 0 ... bit 0 selects lane 3
//   cache_data_in   write data, four byte lanes 0..3 (lane 0 = most significant byte)
//   cache_ready     cache has completed the active request this cycle
//   cache_data_out  read data, four byte lanes 0..3
//
// master: the MEM stage (issues requests); slave: the cache.
interface mem_stage_if;
    logic [31:0]     cache_addr;
    logic            cache_re;
    logic            cache_we;
    logic [3:0]      cache_byte_en;
    logic [3:0][7:0] cache_data_in;
    logic            cache_ready;
    logic [3:0][7:0] cache_data_out;

    modport master (
        output cache_addr, cache_re, cache_we, cache_byte_en, cache_data_in,
        input  cache_ready, cache_data_out
    );

    modport slave (
        input  cache_addr, cache_re, cache_we, cache_byte_en, cache_data_in,
        output cache_ready, cache_data_out
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage between EX/MEM and MEM/WB.
//
// Non-memory instructions pass straight into the MEM/WB registers in one
// cycle. Loads and stores issue one request to the cache, stall upstream in
// WAIT until cache_ready or until MAX_WAIT WAIT cycles elapse (timeout, data
// forced to zero, sticky mem_timeout), then complete into MEM/WB.
//
// Ports:
//   clk, rst_b          clock, asynchronous active-low reset
//   in_valid .. inst    EX/MEM fields (alu_result is the effective address)
//   mem_stall           upstream hold request
//   cache               mem_stage_if.master, cache request/response bus
//   wb_*                registered MEM/WB fields, wb_valid marks a completion
//   mem_misaligned      word access with alu_result[1:0] != 0, request cycle
//   mem_timeout         set on the first timed-out access, held until reset
module mem_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             is_LB_SB,
    input  logic             mem_to_reg,
    input  logic [1:0]       jump,
    input  logic             reg_dst,
    input  logic [31:0]      pc,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      store_data,
    input  logic [31:0]      inst,
    output logic             mem_stall,
    mem_stage_if.master      cache,
    output logic             wb_valid,
    output logic             wb_is_LB_SB,
    output logic [3:0][7:0]  wb_cache_data_out,
    output logic [1:0]       wb_mem_block,
    output logic             wb_mem_to_reg,
    output logic [1:0]       wb_jump,
    output logic [31:0]      wb_pc,
    output logic [31:0]      wb_alu_result,
    output logic [31:0]      wb_inst,
    output logic             wb_reg_dst,
    output logic             mem_misaligned,
    output logic             mem_timeout
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic            live;          // low during reset and the first cycle after release
    logic            new_req, alu_pass;
    logic            ready_done, timeout_done, done;
    logic [3:0]      be_new;
    logic [3:0][7:0] din_new;

    // Request captured at IDLE->WAIT; drives the bus and completion fields in WAIT.
    logic [31:0]     hold_addr;
    logic            hold_re, hold_we;
    logic [3:0]      hold_be;
    logic [3:0][7:0] hold_din;
    logic            hold_lb, hold_m2r, hold_reg_dst;
    logic [1:0]      hold_jump;
    logic [31:0]     hold_pc, hold_alu, hold_inst;

    // live keeps the combinational request path quiet while rst_b is low
    // without feeding the asynchronous reset net into logic.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) live <= 1'b0;
        else        live <= 1'b1;
    end

    assign new_req      = live && (state == IDLE) && in_valid && (mem_read || mem_write);
    assign alu_pass     = live && (state == IDLE) && in_valid && !mem_read && !mem_write;
    assign ready_done   = (state == WAIT) && cache.cache_ready;
    assign timeout_done = (state == WAIT) && !cache.cache_ready &&
                          (wait_cnt == CNT_W'(MAX_WAIT - 1));
    assign done         = ready_done || timeout_done;

    // Byte enables follow the big-endian lane order: bit 3 is lane 0.
    always_comb begin
        be_new  = 4'b1111;
        din_new = '0;
        if (mem_write) begin
            if (is_LB_SB) begin
                be_new                    = 4'b1000 >> alu_result[1:0];
                din_new[alu_result[1:0]]  = store_data[7:0];
            end else begin
                din_new = {store_data[7:0], store_data[15:8],
                           store_data[23:16], store_data[31:24]};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mem_stall = !live;
        case (state)
            IDLE: if (new_req) begin
                state_nxt = WAIT;
                mem_stall = 1'b1;
            end
            WAIT: if (done) state_nxt = IDLE;
                  else      mem_stall = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cache.cache_addr    = '0;
        cache.cache_re      = 1'b0;
        cache.cache_we      = 1'b0;
        cache.cache_byte_en = '0;
        cache.cache_data_in = '0;
        mem_misaligned      = 1'b0;
        if (new_req) begin
            cache.cache_addr    = {alu_result[31:2], 2'b00};
            cache.cache_re      = mem_read && !mem_write;
            cache.cache_we      = mem_write;
            cache.cache_byte_en = be_new;
            cache.cache_data_in = din_new;
            mem_misaligned      = !is_LB_SB && (alu_result[1:0] != 2'b00);
        end else if (state == WAIT) begin
            cache.cache_addr    = hold_addr;
            cache.cache_re      = hold_re;
            cache.cache_we      = hold_we;
            cache.cache_byte_en = hold_be;
            cache.cache_data_in = hold_din;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == WAIT && !done) wait_cnt <= wait_cnt + CNT_W'(1);
            else                        wait_cnt <= '0;
            if (timeout_done) mem_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (new_req) begin
            hold_addr    <= {alu_result[31:2], 2'b00};
            hold_re      <= mem_read && !mem_write;
            hold_we      <= mem_write;
            hold_be      <= be_new;
            hold_din     <= din_new;
            hold_lb      <= is_LB_SB;
            hold_m2r     <= mem_to_reg;
            hold_reg_dst <= reg_dst;
            hold_jump    <= jump;
            hold_pc      <= pc;
            hold_alu     <= alu_result;
            hold_inst    <= inst;
        end
    end

    // MEM/WB boundary
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wb_valid          <= 1'b0;
            wb_is_LB_SB       <= 1'b0;
            wb_cache_data_out <= '0;
            wb_mem_block      <= '0;
            wb_mem_to_reg     <= 1'b0;
            wb_jump           <= '0;
            wb_pc             <= '0;
            wb_alu_result     <= '0;
            wb_inst           <= '0;
            wb_reg_dst        <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (alu_pass) begin
                wb_valid      <= 1'b1;
                wb_is_LB_SB   <= is_LB_SB;
                wb_mem_block  <= alu_result[1:0];
                wb_mem_to_reg <= mem_to_reg;
                wb_jump       <= jump;
                wb_pc         <= pc;
                wb_alu_result <= alu_result;
                wb_inst       <= inst;
                wb_reg_dst    <= reg_dst;
            end else if (done) begin
                wb_valid          <= 1'b1;
                wb_cache_data_out <= ready_done ? cache.cache_data_out : '0;
                wb_is_LB_SB       <= hold_lb;
                wb_mem_block      <= hold_alu[1:0];
                wb_mem_to_reg     <= hold_m2r;
                wb_jump           <= hold_jump;
                wb_pc             <= hold_pc;
                wb_alu_result     <= hold_alu;
                wb_inst           <= hold_inst;
                wb_reg_dst        <= hold_reg_dst;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    localparam int MAX_WAIT = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_b;
    logic            in_valid, mem_read, mem_write, is_LB_SB, mem_to_reg, reg_dst;
    logic [1:0]      jump;
    logic [31:0]     pc, alu_result, store_data, inst;
    logic            mem_stall;
    logic            wb_valid, wb_is_LB_SB, wb_mem_to_reg, wb_reg_dst;
    logic [3:0][7:0] wb_cache_data_out;
    logic [1:0]      wb_mem_block, wb_jump;
    logic [31:0]     wb_pc, wb_alu_result, wb_inst;
    logic            mem_misaligned, mem_timeout;

    mem_stage_if cif();

    mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_b(rst_b),
        .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
        .is_LB_SB(is_LB_SB), .mem_to_reg(mem_to_reg), .jump(jump), .reg_dst(reg_dst),
        .pc(pc), .alu_result(alu_result), .store_data(store_data), .inst(inst),
        .mem_stall(mem_stall), .cache(cif),
        .wb_valid(wb_valid), .wb_is_LB_SB(wb_is_LB_SB), .wb_cache_data_out(wb_cache_data_out),
        .wb_mem_block(wb_mem_block), .wb_mem_to_reg(wb_mem_to_reg), .wb_jump(wb_jump),
        .wb_pc(wb_pc), .wb_alu_result(wb_alu_result), .wb_inst(wb_inst), .wb_reg_dst(wb_reg_dst),
        .mem_misaligned(mem_misaligned), .mem_timeout(mem_timeout)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Expected MEM/WB contents
    logic        e_valid, e_lb, e_m2r, e_rd, e_to;
    logic [1:0]  e_blk, e_jump;
    logic [31:0] e_pc, e_alu, e_inst, e_cdo;

    // Values observed on the bus in the most recent request cycle
    int          n_stall, n_wait, n_mis;
    logic [31:0] o_addr, o_din;
    logic [3:0]  o_be;
    logic        o_we, o_re;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wb(input string tag);
        chk({tag, ".wb_valid"},    wb_valid,          e_valid);
        chk({tag, ".wb_is_LB_SB"}, wb_is_LB_SB,       e_lb);
        chk({tag, ".wb_cdo"},      wb_cache_data_out, e_cdo);
        chk({tag, ".wb_mem_block"},wb_mem_block,      e_blk);
        chk({tag, ".wb_m2r"},      wb_mem_to_reg,     e_m2r);
        chk({tag, ".wb_jump"},     wb_jump,           e_jump);
        chk({tag, ".wb_pc"},       wb_pc,             e_pc);
        chk({tag, ".wb_alu"},      wb_alu_result,     e_alu);
        chk({tag, ".wb_inst"},     wb_inst,           e_inst);
        chk({tag, ".wb_reg_dst"},  wb_reg_dst,        e_rd);
        chk({tag, ".timeout"},     mem_timeout,       e_to);
    endtask

    task automatic model_reset();
        e_valid = 0; e_lb = 0; e_m2r = 0; e_rd = 0; e_to = 0;
        e_blk = 0; e_jump = 0; e_pc = 0; e_alu = 0; e_inst = 0; e_cdo = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        in_valid   = 1'($urandom_range(0, 1));
        mem_read   = 1'($urandom_range(0, 1));
        mem_write  = 1'($urandom_range(0, 1));
        is_LB_SB   = 1'($urandom_range(0, 1));
        mem_to_reg = 1'($urandom_range(0, 1));
        reg_dst    = 1'($urandom_range(0, 1));
        jump       = 2'($urandom_range(0, 3));
        pc = $urandom; alu_result = $urandom; store_data = $urandom; inst = $urandom;
    endtask

    task automatic do_bubble();
        rand_inputs();
        in_valid = 1'b0;
        cif.cache_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("bubble.stall", mem_stall, 1'b0);
        chk("bubble.re", cif.cache_re, 1'b0);
        chk("bubble.we", cif.cache_we, 1'b0);
        tick();
        e_valid = 0;
        check_wb("bubble");
    endtask

    task automatic do_alu(input logic [31:0] a);
        rand_inputs();
        in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; alu_result = a;
        cif.cache_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("alu.stall", mem_stall, 1'b0);
        chk("alu.re", cif.cache_re, 1'b0);
        chk("alu.we", cif.cache_we, 1'b0);
        chk("alu.mis", mem_misaligned, 1'b0);
        tick();
        e_valid = 1; e_lb = is_LB_SB; e_blk = a[1:0]; e_m2r = mem_to_reg; e_jump = jump;
        e_pc = pc; e_alu = a; e_inst = inst; e_rd = reg_dst;
        check_wb("alu");
    endtask

    // lat = WAIT cycle (1-based) in which the cache answers; > MAX_WAIT means never.
    task automatic do_mem(input logic mr, input logic mw, input logic lb,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int lat, input logic [31:0] resp);
        logic        x_we, x_re, x_mis, s_lb, s_m2r, s_rd, fin;
        logic [1:0]  s_jump, blk;
        logic [31:0] x_addr, x_din, s_pc, s_inst;
        logic [3:0]  x_be;
        blk    = a[1:0];
        x_addr = a & 32'hFFFF_FFFC;
        x_we   = mw;
        x_re   = mr & ~mw;
        x_be   = (mw && lb) ? (4'b1000 >> blk) : 4'b1111;
        if (lb) x_din = {24'b0, sd[7:0]} << (8 * blk);
        else for (int i = 0; i < 4; i++) x_din[i*8 +: 8] = sd[(3-i)*8 +: 8];
        x_mis  = !lb && (blk != 2'b00);

        rand_inputs();
        in_valid = 1'b1; mem_read = mr; mem_write = mw; is_LB_SB = lb;
        alu_result = a; store_data = sd;
        s_lb = lb; s_m2r = mem_to_reg; s_rd = reg_dst; s_jump = jump; s_pc = pc; s_inst = inst;
        cif.cache_ready = 1'($urandom_range(0, 1));   // ignored in IDLE
        cif.cache_data_out = $urandom;
        n_stall = 0; n_wait = 0; n_mis = 0;

        @(negedge clk);
        n_stall += int'(mem_stall); n_mis += int'(mem_misaligned);
        o_addr = cif.cache_addr; o_be = cif.cache_byte_en; o_din = cif.cache_data_in;
        o_we = cif.cache_we; o_re = cif.cache_re;
        chk("req.stall", mem_stall, 1'b1);
        chk("req.addr", cif.cache_addr, x_addr);
        chk("req.re", cif.cache_re, x_re);
        chk("req.we", cif.cache_we, x_we);
        chk("req.be", cif.cache_byte_en, x_be);
        if (x_we) chk("req.din", cif.cache_data_in, x_din);
        chk("req.mis", mem_misaligned, x_mis);
        tick();
        e_valid = 0;
        check_wb("req");

        fin = 0;
        for (int k = 1; k <= MAX_WAIT && !fin; k++) begin
            rand_inputs();
            cif.cache_ready    = (k == lat);
            cif.cache_data_out = (k == lat) ? resp : $urandom;
            fin = (k == lat) || (k == MAX_WAIT);
            @(negedge clk);
            n_wait++; n_stall += int'(mem_stall); n_mis += int'(mem_misaligned);
            chk("wait.stall", mem_stall, !fin);
            chk("wait.addr", cif.cache_addr, x_addr);
            chk("wait.re", cif.cache_re, x_re);
            chk("wait.we", cif.cache_we, x_we);
            chk("wait.be", cif.cache_byte_en, x_be);
            if (x_we) chk("wait.din", cif.cache_data_in, x_din);
            chk("wait.mis", mem_misaligned, 1'b0);
            tick();
            if (fin) begin
                e_valid = 1; e_lb = s_lb; e_blk = blk; e_m2r = s_m2r; e_jump = s_jump;
                e_pc = s_pc; e_alu = a; e_inst = s_inst; e_rd = s_rd;
                e_cdo = (k == lat) ? resp : 32'h0;
                if (k != lat) e_to = 1;
            end else begin
                e_valid = 0;
            end
            check_wb("wait");
        end
        cif.cache_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, lat;
        logic mr, mw;

        // Reset with a memory request presented on the inputs
        rst_b = 1'b0;
        model_reset();
        rand_inputs();
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; is_LB_SB = 1'b0; alu_result = 32'h102;
        cif.cache_ready = 1'b1; cif.cache_data_out = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.re", cif.cache_re, 1'b0);
        chk("rst.we", cif.cache_we, 1'b0);
        chk("rst.be", cif.cache_byte_en, 4'b0);
        chk("rst.mis", mem_misaligned, 1'b0);
        check_wb("rst");
        in_valid = 1'b0; cif.cache_ready = 1'b0;
        rst_b = 1'b1;
        tick();

        // ALU pass-through
        do_alu(32'h0000_0042);
        chk("alu42.wb_alu", wb_alu_result, 32'h42);
        chk("alu42.wb_valid", wb_valid, 1'b1);

        // LW 0x100, answered in the third WAIT cycle
        do_mem(1'b1, 1'b0, 1'b0, 32'h100, $urandom, 3, 32'h7856_3412);
        chk("lw.addr", o_addr, 32'h100);
        chk("lw.re", o_re, 1'b1);
        chk("lw.stall_cycles", n_stall, 3);
        chk("lw.lanes", wb_cache_data_out, 32'h7856_3412);
        chk("lw.block", wb_mem_block, 2'd0);

        // SB at 0x203
        do_mem(1'b0, 1'b1, 1'b1, 32'h203, 32'hAABB_CCDD, 2, $urandom);
        chk("sb.addr", o_addr, 32'h200);
        chk("sb.be", o_be, 4'b0001);
        chk("sb.lane3", o_din[31:24], 8'hDD);
        chk("sb.we", o_we, 1'b1);

        // Misaligned LW, and read+write treated as a word write
        do_mem(1'b1, 1'b0, 1'b0, 32'h102, $urandom, 1, $urandom);
        chk("mis.pulses", n_mis, 1);
        chk("mis.addr", o_addr, 32'h100);
        do_mem(1'b1, 1'b1, 1'b0, 32'h40C, 32'h1122_3344, 2, $urandom);
        chk("rw.re", o_re, 1'b0);
        chk("rw.we", o_we, 1'b1);
        chk("rw.din", o_din, 32'h4433_2211);
        do_mem(1'b1, 1'b0, 1'b0, 32'h500, $urandom, 1, 32'hCAFE_F00D);
        do_bubble();

        // Randomized mix against the model
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3) do_bubble();
            else if (r < 6) do_alu($urandom);
            else begin
                mr  = 1'($urandom_range(0, 1));
                mw  = mr ? 1'($urandom_range(0, 1)) : 1'b1;
                lat = $urandom_range(1, MAX_WAIT + 2);
                do_mem(mr, mw, 1'($urandom_range(0, 1)), $urandom, $urandom, lat, $urandom);
            end
        end

        // LB that the cache never answers
        do_mem(1'b1, 1'b0, 1'b1, 32'h601, $urandom, 1000, $urandom);
        chk("to.wait_cycles", n_wait, MAX_WAIT);
        chk("to.data", wb_cache_data_out, 32'h0);
        chk("to.flag", mem_timeout, 1'b1);
        do_alu($urandom);
        chk("to.sticky", mem_timeout, 1'b1);

        // Reset in the middle of WAIT
        rand_inputs();
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; alu_result = 32'h300;
        cif.cache_ready = 1'b0;
        tick();
        repeat (3) tick();
        chk("midrst.re_before", cif.cache_re, 1'b1);
        #3 rst_b = 1'b0;
        #1;
        model_reset();
        chk("midrst.re", cif.cache_re, 1'b0);
        chk("midrst.we", cif.cache_we, 1'b0);
        chk("midrst.be", cif.cache_byte_en, 4'b0);
        check_wb("midrst");
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_b = 1'b1;
        tick();
        check_wb("postrst");
        do_alu(32'h0000_0777);
        do_mem(1'b1, 1'b0, 1'b0, 32'h700, $urandom, 2, 32'h0BAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, meaning the maximum number of WAIT cycles before a cache access is abandoned.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_b, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have upstream inputs from EX/MEM:
- in_valid (1)
- mem_read (1)
- mem_write (1)
- is_LB_SB (1)
- mem_to_reg (1)
- jump (2)
- reg_dst (1)
- pc (32)
- alu_result (32), which is also the effective address
- store_data (32)
- inst (32)
REQ-005 SHALL have output mem_stall (1): the upstream stages hold while it is high.
REQ-006 SHALL have cache-side ports:
- outputs cache_addr (32), cache_re (1), cache_we (1), cache_byte_en (4), cache_data_in (4x8, lanes 0..3)
- inputs cache_ready (1), cache_data_out (4x8, lanes 0..3)
REQ-007 SHALL have registered MEM/WB outputs: wb_valid, wb_is_LB_SB, wb_cache_data_out (4x8), wb_mem_block (2), wb_mem_to_reg, wb_jump (2), wb_pc (32), wb_alu_result (32), wb_inst (32), wb_reg_dst.
REQ-008 SHALL have status outputs mem_misaligned (1, one-cycle pulse) and mem_timeout (1, sticky).

Function
REQ-009 SHALL implement FSM states IDLE and WAIT.
REQ-010 In IDLE with in_valid=1 and mem_read=mem_write=0, the block SHALL capture all pass-through fields into the wb_* registers next edge with wb_valid=1 and mem_stall=0 (latency 1).
REQ-011 In IDLE with in_valid=1 and (mem_read or mem_write), the block SHALL assert cache request signals and mem_stall combinationally, and go to WAIT next edge.
REQ-012 Request encoding:
- cache_addr = {alu_result[31:2],2'b00}; mem_block = alu_result[1:0].
- Word write: cache_byte_en=4'b1111; lanes 0..3 = store_data[31:24], [23:16], [15:8], [7:0] (big-endian).
- Byte write (is_LB_SB=1): one-hot byte_en at lane mem_block; that lane = store_data[7:0].
- Reads: byte_en=4'b1111.
REQ-013 mem_read and mem_write both high SHALL be treated as write only.
REQ-014 In WAIT, cache_addr, cache_re, cache_we, cache_byte_en and cache_data_in SHALL hold constant; mem_stall=1 while cache_ready=0.
REQ-015 In WAIT with cache_ready=1:
- mem_stall SHALL be 0 that cycle.
- wb_cache_data_out SHALL capture cache_data_out; other wb_* fields SHALL capture the held instruction fields; wb_valid=1.
- FSM SHALL return to IDLE.
REQ-016 cache_ready in IDLE SHALL be ignored.
REQ-017 Word access with alu_result[1:0]!=0 SHALL pulse mem_misaligned for the request cycle and still perform the aligned access.
REQ-018 A wait counter SHALL count WAIT cycles. When it reaches MAX_WAIT without cache_ready:
- the access completes as in REQ-015 with wb_cache_data_out = zero;
- mem_timeout is set, and stays set until reset.
REQ-019 The block SHALL emit wb_valid=0 on any edge where no instruction completes (bubble); in that case the other wb_* registers hold their values.
REQ-020 Instruction fields latched at IDLE->WAIT SHALL be used at completion; upstream inputs changing during WAIT SHALL be ignored.
REQ-021 Back-to-back memory instructions SHALL each incur at least one WAIT cycle; there is no request overlap.
REQ-022 cache_re/cache_we SHALL be low whenever no request is active.

Reset
REQ-023 While rst_b=0, the following SHALL all be 0:
- state=IDLE, wait counter, mem_timeout, mem_misaligned
- wb_valid and all wb_* registers
- cache_re, cache_we, cache_byte_en
REQ-024 Reset asserted during WAIT SHALL abandon the access immediately, with no wb_valid produced.

Verification
REQ-025 ALU op, in_valid=1, mem_read=mem_write=0, alu_result=0x0000_0042 -> next edge wb_valid=1, wb_alu_result=0x42, mem_stall never high.
REQ-026 LW at 0x100, cache_ready after 3 WAIT cycles with lanes {0x12,0x34,0x56,0x78}:
- cache_addr=0x100 and re=1 throughout;
- mem_stall high 3 cycles;
- then wb_cache_data_out={0x12,0x34,0x56,0x78}, wb_mem_block=0.
REQ-027 SB at 0x203 with store_data=0xAABBCCDD -> cache_addr=0x200, cache_byte_en=4'b0001 at lane 3, lane3=0xDD, cache_we=1.
REQ-028 LW at 0x102 -> mem_misaligned pulses once, cache_addr=0x100.
REQ-029 LB with cache_ready never asserted, MAX_WAIT=16 -> completes after 16 WAIT cycles; wb_cache_data_out all zero; mem_timeout=1 and stays 1.
REQ-030 rst_b dropped mid-WAIT -> outputs zero asynchronously; after release, state IDLE, no stale wb_valid.
